// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared types and helpers for the PLL supervisor.
//   - pll_state_e   : supervisor state encoding
//   - sup_out_t     : bundle of the Moore-decoded control outputs
//   - cnt_width()   : counter width needed to count 0..max_val-1
//   - retry_inc()   : saturating increment for the retry counter
//   - loss_inc()    : saturating increment for the lock-loss counter
// -----------------------------------------------------------------------------
package pll_sup_pkg;

  localparam int unsigned RETRY_W = 3;
  localparam int unsigned LOSS_W  = 8;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;

  typedef struct packed {
    logic pll_rst;
    logic sys_rst;
    logic ready;
    logic fail;
  } sup_out_t;

  // Bits needed for a counter running 0..max_val-1 (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(max_val);
    end
  endfunction

  // Retry count sticks at its ceiling rather than wrapping back to zero.
  function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
    if (v == {RETRY_W{1'b1}}) begin
      return v;
    end else begin
      return v + 3'd1;
    end
  endfunction

  // Lock-loss count saturates so a flapping PLL never appears healthy again.
  function automatic logic [LOSS_W-1:0] loss_inc(input logic [LOSS_W-1:0] v);
    if (v == {LOSS_W{1'b1}}) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input.
//   clk   : destination clock
//   rst_n : synchronous active-low reset; both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronised output, two clk cycles behind d
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pll_supervisor.sv
// -----------------------------------------------------------------------------
// pll_supervisor
// Brings up the core PLL and gates the core reset on a stable lock.
// Pulses the PLL reset, waits for lock with a timeout, debounces lock over a
// stable window, then releases the core. Bounded retries lead to a sticky
// failure state; lock loss or reinit_req restarts the whole sequence.
// Clocked by the free-running reference clock, never by a PLL output.
//
// Ports:
//   clk        : reference clock (same net as PLL refclk)
//   rst_n      : synchronous active-low reset
//   pll_locked : PLL locked flag, asynchronous to clk
//   reinit_req : single-cycle restart request
//   pll_rst    : PLL reset, active high
//   sys_rst    : core reset, active high, low only in RUN
//   ready      : high only in RUN
//   fail       : high only in FAIL
//   retry_cnt  : failed lock attempts in the current sequence
//   loss_cnt   : lock losses seen in RUN, saturating at 255
// -----------------------------------------------------------------------------
module pll_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 1000000,
  parameter int unsigned STABLE_CYC       = 1024,
  parameter int unsigned MAX_RETRIES      = 4,
  parameter int unsigned CNT_W            = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               reinit_req,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt
);

  // Terminal counts for each timed state.
  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);

  // Output values loaded while rst_n is low.
  localparam sup_out_t OUT_RESET = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fail: 1'b0};

  logic               lock_s;
  pll_state_e         state_r;
  pll_state_e         state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic [RETRY_W-1:0] retry_cnt_r;
  logic [RETRY_W-1:0] retry_nxt_s;
  logic [LOSS_W-1:0]  loss_cnt_r;
  logic [LOSS_W-1:0]  loss_nxt_s;
  sup_out_t           out_r;
  sup_out_t           out_nxt_s;

  sync_2ff #(
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // State, shared counter, event counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= PLL_RST;
      cnt_r       <= '0;
      retry_cnt_r <= '0;
      loss_cnt_r  <= '0;
      out_r       <= OUT_RESET;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      retry_cnt_r <= retry_nxt_s;
      loss_cnt_r  <= loss_nxt_s;
      out_r       <= out_nxt_s;
    end
  end

  // Next-state and counter update; reinit_req overrides every other event.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    retry_nxt_s = retry_cnt_r;
    loss_nxt_s  = loss_cnt_r;
    if (reinit_req) begin
      state_nxt_s = PLL_RST;
      cnt_nxt_s   = '0;
      retry_nxt_s = '0;
    end else begin
      case (state_r)
        PLL_RST: begin
          if (cnt_r == RST_LAST) begin
            state_nxt_s = WAIT_LOCK;
            cnt_nxt_s   = '0;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          // Lock is tested first so it beats a same-cycle timeout.
          if (lock_s) begin
            state_nxt_s = STABLE;
            cnt_nxt_s   = '0;
          end else if (cnt_r == TIMEOUT_LAST) begin
            retry_nxt_s = retry_inc(retry_cnt_r);
            cnt_nxt_s   = '0;
            if (retry_cnt_r == RETRY_LAST) begin
              state_nxt_s = FAIL;
            end else begin
              state_nxt_s = PLL_RST;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        STABLE: begin
          // A dropout is a glitch: back to waiting with a fresh timeout, no retry.
          if (!lock_s) begin
            state_nxt_s = WAIT_LOCK;
            cnt_nxt_s   = '0;
          end else if (cnt_r == STABLE_LAST) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = '0;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        RUN: begin
          cnt_nxt_s = '0;
          if (!lock_s) begin
            state_nxt_s = PLL_RST;
            retry_nxt_s = '0;
            loss_nxt_s  = loss_inc(loss_cnt_r);
          end else begin
            state_nxt_s = RUN;
          end
        end
        FAIL: begin
          // Sticky until rst_n or reinit_req.
          state_nxt_s = FAIL;
          cnt_nxt_s   = '0;
        end
        default: begin
          state_nxt_s = PLL_RST;
          cnt_nxt_s   = '0;
          retry_nxt_s = '0;
        end
      endcase
    end
  end

  // Moore decode of the upcoming state so outputs flip on the same edge as state.
  always_comb begin
    out_nxt_s = OUT_RESET;
    case (state_nxt_s)
      PLL_RST:   out_nxt_s = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fail: 1'b0};
      WAIT_LOCK: out_nxt_s = '{pll_rst: 1'b0, sys_rst: 1'b1, ready: 1'b0, fail: 1'b0};
      STABLE:    out_nxt_s = '{pll_rst: 1'b0, sys_rst: 1'b1, ready: 1'b0, fail: 1'b0};
      RUN:       out_nxt_s = '{pll_rst: 1'b0, sys_rst: 1'b0, ready: 1'b1, fail: 1'b0};
      FAIL:      out_nxt_s = '{pll_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0, fail: 1'b1};
      default:   out_nxt_s = OUT_RESET;
    endcase
  end

  assign pll_rst   = out_r.pll_rst;
  assign sys_rst   = out_r.sys_rst;
  assign ready     = out_r.ready;
  assign fail      = out_r.fail;
  assign retry_cnt = retry_cnt_r;
  assign loss_cnt  = loss_cnt_r;

endmodule

// File: doc/pll_supervisor.md
Name: pll_supervisor

Overview:
- Controller on the other end of the core PLL: drives the PLL's `rst`, consumes its asynchronous `locked`, and produces the core system reset.
- Pulses the PLL reset, waits for lock with a timeout, then debounces lock for a stable window before releasing the core.
- Retries a bounded number of times before flagging failure, and re-initialises on lock loss or on request (e.g. video-mode / clock reconfiguration).
- Runs on the free-running 50 MHz reference clock, never on a PLL output.

Parameters:
- RST_PULSE_CYC, 16: cycles `pll_rst` is held high per attempt (≥1).
- LOCK_TIMEOUT_CYC, 1000000: cycles allowed in WAIT_LOCK before a retry (20 ms at 50 MHz).
- STABLE_CYC, 1024: consecutive synchronised-lock cycles required before release.
- MAX_RETRIES, 4: failed attempts allowed before FAIL (≥1).
- CNT_W, 20: width of the shared cycle counter; must hold max(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC)-1.

Ports:
- clk, in, 1: 50 MHz reference clock (same net as the PLL `refclk`).
- rst_n, in, 1: synchronous, active-low reset.
- pll_locked, in, 1: PLL `locked`; asynchronous to `clk`.
- reinit_req, in, 1: single-cycle request to restart the PLL from scratch.
- pll_rst, out, 1: to the PLL `rst` input; active high.
- sys_rst, out, 1: core reset; active high; low only in RUN.
- ready, out, 1: high only in RUN.
- fail, out, 1: high only in FAIL.
- retry_cnt, out, 3: failed lock attempts in the current sequence.
- loss_cnt, out, 8: lock losses seen while in RUN; saturates at 255.

Behaviour:
- **Lock synchronisation:** `pll_locked` passes through a 2-FF synchroniser to give `lock_s`. This is 2 cycles of latency; all decisions use `lock_s` only.
- **Register timing:** state, counter and all outputs are registered. Outputs are Moore decodes, registered so they change on the same edge as the state.
- **Reset (rst_n=0 at an edge):**
  - state=PLL_RST, cnt=0, retry_cnt=0, loss_cnt=0, synchroniser cleared.
  - pll_rst=1, sys_rst=1, ready=0, fail=0.
- **PLL_RST:**
  - pll_rst=1, sys_rst=1.
  - cnt increments each cycle. At cnt==RST_PULSE_CYC-1, go to WAIT_LOCK with cnt=0.
  - Net effect: `pll_rst` is high for exactly RST_PULSE_CYC cycles after reset release.
- **WAIT_LOCK:**
  - pll_rst=0, sys_rst=1.
  - lock_s=1: go to STABLE, cnt=0.
  - Otherwise cnt increments. At cnt==LOCK_TIMEOUT_CYC-1 a timeout occurs:
    - if retry_cnt==MAX_RETRIES-1: retry_cnt++ and go to FAIL;
    - else: retry_cnt++ and go to PLL_RST with cnt=0.
- **STABLE:**
  - pll_rst=0, sys_rst=1.
  - lock_s=0: go to WAIT_LOCK with cnt=0. This is a glitch, not a retry; the timeout restarts.
  - lock_s=1 and cnt==STABLE_CYC-1: go to RUN. Otherwise cnt increments.
- **RUN:**
  - sys_rst=0, ready=1.
  - lock_s=0: go to PLL_RST with cnt=0, retry_cnt=0, and loss_cnt+1 (saturating).
- **FAIL:**
  - pll_rst=1, sys_rst=1, fail=1.
  - Held indefinitely; exits only via rst_n or reinit_req.
- **reinit_req=1, any state:** go to PLL_RST with cnt=0 and retry_cnt=0; loss_cnt is unchanged.
  - Highest priority after rst_n: it overrides a same-cycle timeout, lock, or lock-loss transition.
  - reinit_req held high keeps the block in PLL_RST with cnt=0.
- **Simultaneous events:**
  - Timeout and lock_s rising on the same cycle in WAIT_LOCK: lock wins.
  - lock_s dropping on the same cycle cnt reaches STABLE_CYC-1: go to WAIT_LOCK.
- **Counters:** cnt never wraps; it is cleared on every state change. retry_cnt saturates at 7.

Decomposition:
- Package `pll_sup_pkg`: state enum {PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL} and a clog2-based counter-width helper.
- Sub-module `sync_2ff`: 1-bit, parameterisable reset value (0 here), for `pll_locked`; reused for other async inputs.

Test Plan:
All tests use RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=64, STABLE_CYC=8, MAX_RETRIES=2. Model: `pll_locked` rises 10 cycles after `pll_rst` falls.
1. Release rst_n at edge 0 -> pll_rst high for edges 0–3, low from edge 4; lock_s at +2; ready=1 and sys_rst=0 exactly 8 cycles after entering STABLE; retry_cnt=0.
2. pll_locked tied 0 -> two timeouts 64 cycles apart with a 4-cycle pll_rst pulse between; then fail=1, retry_cnt=2, pll_rst stays 1.
3. In RUN, drop pll_locked for 5 cycles -> ready=0 and pll_rst=1 two cycles after the drop; loss_cnt=1; full sequence recovers to RUN.
4. In STABLE at cnt=3, pulse pll_locked low 1 cycle -> back to WAIT_LOCK, no retry increment; RUN reached 8 clean cycles after lock returns.
5. In FAIL, pulse reinit_req -> fail=0, retry_cnt=0, pll_rst pulses 4 cycles, normal lock reaches RUN; reinit_req in RUN -> immediate sys_rst=1 with loss_cnt unchanged.
6. Assert rst_n=0 mid-WAIT_LOCK with retry_cnt=1 -> next edge: all outputs at reset values, counters 0.
